// File: rtl/d_flip_flop.sv
// d_flip_flop: positive-edge D register with synchronous, active-high reset.
// WIDTH sets the data width; RESET_VALUE is the value loaded while rest is high.
// q is driven straight from the register, so there is no combinational path
// from any input to the output.
module d_flip_flop #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next state: reset wins over data, otherwise follow d.
    always_comb begin
        q_d = d;
        if (rest) begin
            q_d = RESET_VALUE;
        end
    end

    // Storage element, updated only on the rising clock edge.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of the default 1-bit flop and an 8-bit
// instance with a non-zero reset value. Clock period 60 ns, first rising
// edge at 30 ns; outputs are sampled 1 ns after the edge.
module tb_d_flip_flop;

    logic       clk;
    logic       rest;
    logic       d;
    logic       q;

    logic       rest8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks;
    int errors;

    d_flip_flop dut (
        .clk  (clk),
        .rest (rest),
        .d    (d),
        .q    (q)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk  (clk),
        .rest (rest8),
        .d    (d8),
        .q    (q8)
    );

    initial begin
        clk = 1'b0;
        forever #30 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        // rest high from time 0 with d undriven, held over two edges
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge: q=%b required 0", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: q=%b required 0", q);
        end
    endtask

    task automatic test_release();
        // at 100 ns: release reset with d=0
        #9;
        rest = 1'b0;
        d    = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL release_d0: q=%b required 0", q);
        end
    endtask

    task automatic test_capture();
        // at 200 ns: d=1; q must wait for the 210 ns edge
        #49;
        d = 1'b1;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL capture_before_edge: q=%b required 0", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL capture_at_edge: q=%b required 1", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL capture_hold: q=%b required 1", q);
        end
    endtask

    task automatic test_midcycle();
        // toggle d between edges; q must hold 1 until the next edge, then take 0
        for (int i = 0; i < 6; i++) begin
            #5;
            d = ~d;
            #1;
            checks++;
            if (q !== 1'b1) begin
                errors++;
                $display("FAIL midcycle_glitch_%0d: q=%b required 1", i, q);
            end
        end
        d = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL midcycle_edge: q=%b required 0", q);
        end
        // rest toggling mid-cycle must not touch q either
        rest = 1'b1;
        #5;
        rest = 1'b0;
        d = 1'b1;
        #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL midcycle_rest_pulse: q=%b required 0", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL recapture_1: q=%b required 1", q);
        end
    endtask

    task automatic test_reset_priority();
        // q=1 now; rest and d both high for one edge
        rest = 1'b1;
        d    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: q=%b required 0", q);
        end
        rest = 1'b0;
        d    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_d1: q=%b required 1", q);
        end
    endtask

    task automatic test_param();
        rest8 = 1'b1;
        d8    = 8'hFF;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'hA5) begin
            errors++;
            $display("FAIL param_reset: q8=%h required a5", q8);
        end
        d8 = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'hA5) begin
            errors++;
            $display("FAIL param_reset_held: q8=%h required a5", q8);
        end
        rest8 = 1'b0;
        d8    = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'h3C) begin
            errors++;
            $display("FAIL param_capture_3c: q8=%h required 3c", q8);
        end
        d8 = 8'h5A;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'h5A) begin
            errors++;
            $display("FAIL param_capture_5a: q8=%h required 5a", q8);
        end
        rest8 = 1'b1;
        d8    = 8'hC3;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'hA5) begin
            errors++;
            $display("FAIL param_mid_reset: q8=%h required a5", q8);
        end
        rest8 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q8 !== 8'hC3) begin
            errors++;
            $display("FAIL param_release_c3: q8=%h required c3", q8);
        end
    endtask

    task automatic test_back_to_back();
        // new sample every cycle on the 1-bit flop
        logic [7:0] pattern;
        pattern = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            d = pattern[i];
            @(posedge clk); #1;
            checks++;
            if (q !== pattern[i]) begin
                errors++;
                $display("FAIL back_to_back_%0d: q=%b required %b", i, q, pattern[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rest   = 1'b1;
        d      = 1'bx;
        rest8  = 1'b1;
        d8     = 8'hxx;

        test_reset();
        test_release();
        test_capture();
        test_midcycle();
        test_reset_priority();
        test_param();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
